// File: rtl/seg_fader_if.sv
// Pattern interface between the 7-segment generator, the fader and the pads.
// The master side drives the incoming pattern; the slave (fader) drives the blended output.
interface seg_fader_if;
   logic [6:0] i_segment;
   logic [6:0] o_segment;
   logic       o_busy;

   modport master (
      output i_segment,
      input  o_segment,
      input  o_busy
   );

   modport slave (
      input  i_segment,
      output o_segment,
      output o_busy
   );
endinterface

// File: rtl/seg_fader.sv
// Cross-fade between successive 7-segment patterns using a per-segment PWM duty ramp.
// A two-stage synchroniser qualifies a new pattern; each fade steps the duty level up once per HOLD_PERIODS PWM periods.
module seg_fader #(
   parameter int unsigned PWM_BITS     = 4,
   parameter int unsigned HOLD_PERIODS = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   seg_fader_if.slave  seg
);

   localparam int unsigned HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
   localparam logic [PWM_BITS:0]   LVL_LAST  = (PWM_BITS + 1)'((1 << PWM_BITS) - 1);

   typedef enum logic {
      IDLE,
      FADE
   } state_t;

   state_t              state, state_nx;
   logic [6:0]          r_s1, r_s2;
   logic [6:0]          r_old, r_new, r_out;
   logic [6:0]          old_nx, new_nx, out_nx;
   logic [PWM_BITS-1:0] r_pwm, pwm_nx;
   logic [PWM_BITS:0]   r_lvl, lvl_nx;
   logic [HOLD_W-1:0]   r_hold, hold_nx;
   logic                cand_valid;
   logic                pwm_on;

   assign cand_valid    = (r_s2 == r_s1);
   // Level is one bit wider so it can express "all phases on" without aliasing to zero.
   assign pwm_on        = ({1'b0, r_pwm} < r_lvl);
   assign seg.o_segment = r_out;
   assign seg.o_busy    = (state == FADE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         r_s1   <= '0;
         r_s2   <= '0;
         r_old  <= '0;
         r_new  <= '0;
         r_out  <= '0;
         r_pwm  <= '0;
         r_lvl  <= '0;
         r_hold <= '0;
      end else begin
         state  <= state_nx;
         r_s1   <= seg.i_segment;
         r_s2   <= r_s1;
         r_old  <= old_nx;
         r_new  <= new_nx;
         r_out  <= out_nx;
         r_pwm  <= pwm_nx;
         r_lvl  <= lvl_nx;
         r_hold <= hold_nx;
      end
   end

   always_comb begin
      state_nx = state;
      old_nx   = r_old;
      new_nx   = r_new;
      out_nx   = r_new;
      pwm_nx   = r_pwm;
      lvl_nx   = r_lvl;
      hold_nx  = r_hold;

      case (state)
         IDLE: begin
            if (cand_valid && (r_s2 != r_new)) begin
               old_nx   = r_new;
               new_nx   = r_s2;
               pwm_nx   = '0;
               lvl_nx   = '0;
               hold_nx  = '0;
               state_nx = FADE;
            end
         end

         FADE: begin
            for (int unsigned i = 0; i < 7; i++) begin
               out_nx[i] = pwm_on ? r_new[i] : r_old[i];
            end
            pwm_nx = r_pwm + PWM_BITS'(1);
            if (r_pwm == '1) begin
               if (r_hold == HOLD_LAST) begin
                  hold_nx = '0;
                  // Leaving from the top level means no cycle is ever spent at full duty.
                  if (r_lvl == LVL_LAST) begin
                     lvl_nx   = '0;
                     state_nx = IDLE;
                  end else begin
                     lvl_nx = r_lvl + (PWM_BITS + 1)'(1);
                  end
               end else begin
                  hold_nx = r_hold + HOLD_W'(1);
               end
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seg_fader.sv
// Self-checking bench for seg_fader: a cycle model feeds a scoreboard queue that is drained every cycle,
// and directed scenarios check fade length, duty, glitch rejection, mid-fade changes and reset.
module tb_seg_fader;

   localparam int PWM_BITS = 4;
   localparam int HOLD     = 2;
   localparam int PER      = 1 << PWM_BITS;
   localparam int LVL_LEN  = PER * HOLD;
   localparam int FADE_LEN = LVL_LEN * PER;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg_fader_if sif ();

   seg_fader #(
      .PWM_BITS     (PWM_BITS),
      .HOLD_PERIODS (HOLD)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .seg   (sif)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_5b   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the fade is tracked as a single elapsed-cycle counter.
   logic [6:0] m_s1, m_s2, m_old, m_new;
   logic       m_fade;
   int         m_t;
   logic [7:0] sb[$];

   function automatic logic [6:0] model_out(input logic fade, input int t,
                                            input logic [6:0] old_v, input logic [6:0] new_v);
      logic [6:0] r;
      r = new_v;
      if (fade) r = ((t % PER) < (t / LVL_LEN)) ? new_v : old_v;
      return r;
   endfunction

   function automatic logic model_start(input logic fade, input logic [6:0] s1,
                                        input logic [6:0] s2, input logic [6:0] nv);
      return !fade && (s2 == s1) && (s2 != nv);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_s1 <= '0; m_s2 <= '0; m_old <= '0; m_new <= '0; m_fade <= 1'b0; m_t <= 0;
         sb.push_back(8'h00);
      end else begin
         sb.push_back({ m_fade ? (m_t != FADE_LEN - 1) : model_start(m_fade, m_s1, m_s2, m_new),
                        model_out(m_fade, m_t, m_old, m_new) });
         m_s1 <= sif.i_segment;
         m_s2 <= m_s1;
         if (m_fade) begin
            m_t    <= (m_t == FADE_LEN - 1) ? 0 : m_t + 1;
            m_fade <= (m_t != FADE_LEN - 1);
         end else if (model_start(m_fade, m_s1, m_s2, m_new)) begin
            m_old  <= m_new;
            m_new  <= m_s2;
            m_t    <= 0;
            m_fade <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         logic [7:0] e;
         e = sb.pop_front();
         check("sb_seg", 32'(sif.o_segment), 32'(e[6:0]));
         check("sb_busy", 32'(sif.o_busy), 32'(e[7]));
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sif.o_segment == 7'h5B) cnt_5b++;
      end
   endtask

   task automatic wait_busy(input logic lvl, input int limit, output int n);
      n = 0;
      while (sif.o_busy !== lvl && n < limit) begin
         @(negedge clk);
         n++;
         if (sif.o_segment == 7'h5B) cnt_5b++;
      end
   endtask

   task automatic run_fade(input logic [6:0] v);
      int n;
      sif.i_segment = v;
      wait_busy(1'b1, 8, n);
      check("fade_start", n, 3);
      wait_busy(1'b0, FADE_LEN + 50, n);
      check("fade_len", n, FADE_LEN);
      @(negedge clk);
      check("fade_final", 32'(sif.o_segment), 32'(v));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n, cnt_on, cnt_off, viol, mix, bad;
      logic [6:0] trace[FADE_LEN];
      logic [6:0] s;

      // Reset with a full pattern pending, then fade in from blank.
      rst = 1'b1;
      sif.i_segment = 7'h7F;
      repeat (3) begin
         @(negedge clk);
         check("rst_seg", 32'(sif.o_segment), 0);
         check("rst_busy", 32'(sif.o_busy), 0);
      end
      rst = 1'b0;
      wait_busy(1'b1, 8, n);
      check("fadein_start_ok", 32'(n == 2 || n == 3), 1);
      wait_busy(1'b0, FADE_LEN + 50, n);
      check("fadein_len", n, FADE_LEN);
      @(negedge clk);
      check("fadein_final", 32'(sif.o_segment), 32'h7F);

      // Duty ramp 00 -> 7F.
      run_fade(7'h00);
      sif.i_segment = 7'h7F;
      wait_busy(1'b1, 8, n);
      check("duty_start", n, 3);
      for (int j = 0; j < FADE_LEN; j++) begin
         trace[j] = sif.o_segment;
         @(negedge clk);
      end
      cnt_on = 0; cnt_off = 0;
      for (int j = 1 + 8 * LVL_LEN; j < 1 + 8 * LVL_LEN + PER; j++)
         if (trace[j] == 7'h7F) cnt_on++;
      for (int j = 1; j < 1 + PER; j++)
         if (trace[j] == 7'h00) cnt_off++;
      check("duty_lvl8_on", cnt_on, 8);
      check("duty_lvl0_off", cnt_off, PER);
      wait_busy(1'b0, 10, n);
      @(negedge clk);
      check("duty_final", 32'(sif.o_segment), 32'h7F);

      // Common bits 0F -> 3C.
      run_fade(7'h0F);
      sif.i_segment = 7'h3C;
      wait_busy(1'b1, 8, n);
      viol = 0; mix = 0;
      for (int j = 0; j < FADE_LEN + 2; j++) begin
         s = sif.o_segment;
         if (s[3:2] != 2'b11 || s[6] != 1'b0) viol++;
         if (s[0] != s[1] || s[4] != s[5] || s[0] == s[4]) viol++;
         if (s == 7'h3C && sif.o_busy) mix++;
         @(negedge clk);
      end
      check("common_viol", viol, 0);
      check("common_mixed", 32'(mix > 0), 1);
      check("common_final", 32'(sif.o_segment), 32'h3C);

      // One-cycle glitch and re-applied pattern.
      run_fade(7'h3F);
      sif.i_segment = 7'h06;
      @(negedge clk);
      sif.i_segment = 7'h3F;
      bad = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (sif.o_busy !== 1'b0 || sif.o_segment !== 7'h3F) bad++;
         sif.i_segment = 7'h3F;
      end
      check("glitch_bad", bad, 0);

      // Pattern changes while fading.
      run_fade(7'h00);
      cnt_5b = 0;
      sif.i_segment = 7'h06;
      wait_busy(1'b1, 8, n);
      tick(100);
      sif.i_segment = 7'h5B;
      tick(100);
      sif.i_segment = 7'h4F;
      wait_busy(1'b0, FADE_LEN, n);
      check("mid_len1", n + 200, FADE_LEN);
      check("mid_first_new", 32'(dut.r_new), 32'h06);
      wait_busy(1'b1, 5, n);
      check("mid_gap", n, 1);
      wait_busy(1'b0, FADE_LEN + 50, n);
      check("mid_len2", n, FADE_LEN);
      tick(1);
      check("mid_final", 32'(sif.o_segment), 32'h4F);
      check("mid_no_5b", cnt_5b, 0);

      // Reset in the middle of a fade.
      sif.i_segment = 7'h1C;
      wait_busy(1'b1, 8, n);
      tick(300);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_seg", 32'(sif.o_segment), 0);
      check("rstmid_busy", 32'(sif.o_busy), 0);
      rst = 1'b0;
      wait_busy(1'b1, 8, n);
      check("rstmid_restart", n, 3);
      wait_busy(1'b0, FADE_LEN + 50, n);
      check("rstmid_len", n, FADE_LEN);
      @(negedge clk);
      check("rstmid_final", 32'(sif.o_segment), 32'h1C);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
